// File: rtl/mmx_exec_stage.sv
// mmx_exec_stage: two-stage MMX execute/writeback pipeline around an external SIMD unit
module mmx_exec_stage #(
  parameter int NREGS = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(NREGS)-1:0] in_dst,
  input  logic [$clog2(NREGS)-1:0] in_src,
  input  logic                     in_src_mem,
  input  logic [WIDTH-1:0]         in_mem_data,
  input  logic                     flush,
  output logic [WIDTH-1:0]         simd_mm,
  output logic [WIDTH-1:0]         simd_mm64,
  output logic [2:0]               simd_op,
  input  logic [WIDTH-1:0]         simd_out,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [$clog2(NREGS)-1:0] wb_reg,
  output logic [WIDTH-1:0]         wb_data,
  output logic                     illegal_op
);
  localparam int AW = $clog2(NREGS);

  logic             r_e_valid, r_e_mem, r_wb_valid, r_ill;
  logic [2:0]       r_e_op;
  logic [AW-1:0]    r_e_dst, r_e_src, r_wb_reg;
  logic [WIDTH-1:0] r_e_data, r_wb_data;
  logic [WIDTH-1:0] r_mm [NREGS];
  logic             w_w_adv, w_e_adv, w_e_go, w_take, w_acc, w_ill;

  assign w_w_adv    = r_wb_valid & wb_ready;
  assign w_e_adv    = r_e_valid & (!r_wb_valid | w_w_adv);
  assign w_e_go     = w_e_adv & !flush;
  assign in_ready   = !r_e_valid | w_e_adv;
  assign w_take     = in_valid & in_ready & !flush;
  assign w_acc      = w_take & (in_op <= 3'd4);
  assign w_ill      = w_take & (in_op > 3'd4);
  assign simd_op    = r_e_op;
  assign simd_mm    = (r_wb_valid && r_wb_reg == r_e_dst) ? r_wb_data : r_mm[r_e_dst];
  assign simd_mm64  = r_e_mem ? r_e_data :
                      (r_wb_valid && r_wb_reg == r_e_src) ? r_wb_data : r_mm[r_e_src];
  assign wb_valid   = r_wb_valid;
  assign wb_reg     = r_wb_reg;
  assign wb_data    = r_wb_data;
  assign illegal_op = r_ill;

  // E stage: capture accepted legal op; flush kills it, advancing into W empties it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_valid <= 1'b0;
      r_e_op    <= '0;
      r_e_dst   <= '0;
      r_e_src   <= '0;
      r_e_mem   <= 1'b0;
      r_e_data  <= '0;
    end else begin
      r_e_valid <= !flush & (w_acc | (r_e_valid & !w_e_adv));
      if (w_acc) begin
        r_e_op   <= in_op;
        r_e_dst  <= in_dst;
        r_e_src  <= in_src;
        r_e_mem  <= in_src_mem;
        r_e_data <= in_mem_data;
      end
    end
  end

  // W stage: hold SIMD result until retired; a flushed E op never reaches W
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
      r_ill      <= 1'b0;
    end else begin
      r_wb_valid <= w_e_go | (r_wb_valid & !wb_ready);
      r_ill      <= w_ill;
      if (w_e_go) begin
        r_wb_reg  <= r_e_dst;
        r_wb_data <= simd_out;
      end
    end
  end

  // Register file: written only when W retires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_mm[i] <= '0;
    end else if (w_w_adv) begin
      r_mm[r_wb_reg] <= r_wb_data;
    end
  end
endmodule
